fir_cmplx_decim: RTL and testbench
==================================

Name: fir_cmplx_decim

Overview:
- Complex channel-select FIR with integrated decimation.
- Sits directly downstream of the IQ reader. It consumes the quantized I and Q sample streams from two FWFT FIFOs and low-pass filters both with one real coefficient set.
- Emits one filtered I/Q pair per DECIM input pairs to two output FIFOs that feed the FM demodulator.
- Uses one serial MAC per channel, one tap per cycle.

Parameters:
- TAPS, 20: filter length; history depth per channel.
- DECIM, 10: input pairs consumed per output pair.
- BITS, 10: quantization fraction bits; dequantize divides by 2^BITS.
- COEFFS, channel LPF table: TAPS x 32-bit signed quantized coefficients; index 0 multiplies the newest sample.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_i_rd_en  out  1  pop I FIFO
- in_i_empty  in  1  I FIFO empty
- in_i_dout  in  32  I sample, signed, valid while !empty (FWFT)
- in_q_rd_en  out  1  pop Q FIFO
- in_q_empty  in  1  Q FIFO empty
- in_q_dout  in  32  Q sample, signed, FWFT
- out_i_wr_en  out  1  push filtered I
- out_i_full  in  1  I out FIFO full
- out_i_din  out  32  filtered I, signed
- out_q_wr_en  out  1  push filtered Q
- out_q_full  in  1  Q out FIFO full
- out_q_din  out  32  filtered Q, signed

Behaviour:
- Reset (async, active-high; clock is clock):
  - State goes to S_FILL; sample counter 0; tap index 0.
  - Both accumulators 0; all 2xTAPS history registers 0.
  - All rd_en/wr_en outputs 0; din outputs 0.
- Reset mid-operation discards any partial accumulation and history. The first output after reset needs a fresh DECIM pairs.
- rd_en and wr_en are combinational from state and flags. All other outputs are registered or derived from registers.
- S_FILL:
  - When !in_i_empty && !in_q_empty: assert in_i_rd_en and in_q_rd_en in the same cycle.
  - Shift history: x[k] <= x[k-1] for k = TAPS-1 down to 1; x[0] <= dout. Applies to I and Q.
  - Increment the sample counter.
  - If only one FIFO is non-empty: no pop, no shift, hold.
  - When the counter reaches DECIM-1 and a pop occurs: counter <= 0, accumulators <= 0, tap <= 0, go to S_MAC.
- S_MAC:
  - Runs exactly TAPS cycles; no FIFO activity.
  - Each cycle: acc_i += DQ(COEFFS[tap] * x_i[tap]); acc_q += DQ(COEFFS[tap] * x_q[tap]); tap++.
  - After the tap = TAPS-1 update, go to S_OUT.
- Arithmetic:
  - Product is 64-bit signed.
  - DQ(p) = p / 2^BITS truncated toward zero, not an arithmetic shift. Negative p is biased by 2^BITS-1 before the shift.
  - The DQ result is truncated to 32 bits.
  - Accumulators are 32-bit signed and wrap; no saturation.
- S_OUT:
  - out_i_din = acc_i and out_q_din = acc_q, held stable throughout S_OUT.
  - When !out_i_full && !out_q_full: assert both wr_en for one cycle, go to S_FILL.
  - If either FIFO is full: no write, hold, no input pops (backpressure propagates).
- Latency: from the cycle of the DECIM-th pop to the wr_en cycle is TAPS+1 cycles, absent backpressure.
- Throughput: one output per DECIM + TAPS + 1 cycles at best.
- Outputs are never written singly. I and Q stay pair-aligned at all times.

Test Plan:
- Impulse: I pair 0 = 1024 then zeros, Q all 0 (default parameters) -> out_i sequence = COEFFS[9], COEFFS[19], 0, 0…; out_q all 0. First wr_en exactly 21 cycles after the 10th pop.
- DC: I = Q = 1024 constant for 40 pairs -> outputs 3 and 4 equal sum over k of DQ(COEFFS[k]*1024) on both channels.
- Rounding: COEFFS[0] = -3, others 0, I = 1 -> out_i = 0, not -1. COEFFS[0] = -2048, I = 1 -> out_i = -2.
- Flag skew: in_i_empty = 0, in_q_empty = 1 for 5 cycles -> no rd_en and no history shift. Release -> paired pops resume and the output matches the unskewed run.
- Backpressure: out_q_full = 1 for 8 cycles in S_OUT -> no wr_en on either output, din stable, no rd_en. Release -> one paired write, then normal flow.
- Reset in S_MAC (tap 7) -> all outputs 0 immediately. The next output requires 10 new pairs and reflects no pre-reset history.

Source files
------------

// File: rtl/fir_cmplx_decim.sv
// fir_cmplx_decim: complex channel-select FIR with integrated decimation.
//
// Pops paired I/Q samples from two FWFT FIFOs into a TAPS-deep history per
// channel. After every DECIM pairs it runs one serial MAC per channel, one tap
// per cycle, using a single real coefficient set. It then pushes the filtered
// I/Q pair into two output FIFOs. Pops and pushes are always paired, so I and
// Q never drift apart.
//
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   in_i_rd_en / in_q_rd_en  pop the I / Q input FIFO (combinational)
//   in_i_empty / in_q_empty  input FIFO empty flags
//   in_i_dout  / in_q_dout   signed input samples, valid while !empty
//   out_i_wr_en/out_q_wr_en  push the I / Q output FIFO (combinational)
//   out_i_full / out_q_full  output FIFO full flags
//   out_i_din  / out_q_din   signed filtered samples (registered)
module fir_cmplx_decim #(
  parameter int TAPS  = 20,
  parameter int DECIM = 10,
  parameter int BITS  = 10,
  parameter logic signed [31:0] COEFFS [TAPS] = '{
    -2, -5, -9, -7, 3, 26, 63, 110, 152, 181,
    184, 158, 117, 67, 27, 4, -6, -8, -3, 1
  }
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_i_rd_en,
  input  logic        in_i_empty,
  input  logic [31:0] in_i_dout,
  output logic        in_q_rd_en,
  input  logic        in_q_empty,
  input  logic [31:0] in_q_dout,
  output logic        out_i_wr_en,
  input  logic        out_i_full,
  output logic [31:0] out_i_din,
  output logic        out_q_wr_en,
  input  logic        out_q_full,
  output logic [31:0] out_q_din
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  // Negative products are biased so the shift rounds toward zero like a divide.
  localparam logic signed [63:0] DQ_BIAS = (64'sd1 <<< BITS) - 64'sd1;

  typedef enum logic [1:0] {
    S_FILL,
    S_MAC,
    S_OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic signed [31:0]      acc_i_q, acc_i_d;
  logic signed [31:0]      acc_q_q, acc_q_d;
  logic signed [31:0]      x_i_q [TAPS];
  logic signed [31:0]      x_i_d [TAPS];
  logic signed [31:0]      x_q_q [TAPS];
  logic signed [31:0]      x_q_d [TAPS];

  logic                    pop;
  logic                    push;
  logic signed [63:0]      coef_ext;
  logic signed [63:0]      prod_i;
  logic signed [63:0]      prod_q;

  // Dequantize: divide by 2^BITS truncating toward zero, keep the low 32 bits.
  function automatic logic signed [31:0] dq(input logic signed [63:0] p);
    logic signed [63:0] biased;
    biased = p[63] ? (p + DQ_BIAS) : p;
    return 32'(biased >>> BITS);
  endfunction

  // Pops need both inputs available; pushes need both outputs to have room.
  // Gating with reset keeps the FIFOs untouched while the block is held.
  assign pop  = (state_q == S_FILL) && !in_i_empty && !in_q_empty && !reset;
  assign push = (state_q == S_OUT) && !out_i_full && !out_q_full && !reset;

  assign in_i_rd_en  = pop;
  assign in_q_rd_en  = pop;
  assign out_i_wr_en = push;
  assign out_q_wr_en = push;

  // Accumulators only change outside S_OUT, so they double as the held outputs.
  assign out_i_din = acc_i_q;
  assign out_q_din = acc_q_q;

  always_comb begin
    coef_ext = 64'(COEFFS[tap_q]);
    prod_i   = coef_ext * 64'(x_i_q[tap_q]);
    prod_q   = coef_ext * 64'(x_q_q[tap_q]);
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    x_i_d   = x_i_q;
    x_q_d   = x_q_q;

    unique case (state_q)
      S_FILL: begin
        if (pop) begin
          for (int k = TAPS - 1; k > 0; k--) begin
            x_i_d[k] = x_i_q[k-1];
            x_q_d[k] = x_q_q[k-1];
          end
          x_i_d[0] = in_i_dout;
          x_q_d[0] = in_q_dout;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            tap_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_MAC: begin
        acc_i_d = acc_i_q + dq(prod_i);
        acc_q_d = acc_q_q + dq(prod_q);
        if (tap_q == TAP_LAST) begin
          state_d = S_OUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end

      S_OUT: begin
        if (push) begin
          state_d = S_FILL;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      tap_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      // NOTE: the history is reset on purpose: an output after reset must not
      // see samples from before it, so these stay flops rather than a RAM.
      x_i_q   <= '{default: '0};
      x_q_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      x_i_q   <= x_i_d;
      x_q_q   <= x_q_d;
    end
  end

endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Testbench for fir_cmplx_decim. Two instances: u_dut with the default LPF
// table, u_rnd with a sparse table for the round-toward-zero cases. Input
// FIFOs are modelled by queues (FWFT front on dout), stimulus pushes expected
// outputs into scoreboard queues, and a negedge monitor pops and compares on
// every output write.
`timescale 1ns/1ps
module tb_fir_cmplx_decim;

  localparam int TAPS  = 20;
  localparam int DECIM = 10;
  localparam int BITS  = 10;
  localparam longint SCALE = longint'(1) << BITS;

  localparam int C [TAPS] = '{
    -2, -5, -9, -7, 3, 26, 63, 110, 152, 181,
    184, 158, 117, 67, 27, 4, -6, -8, -3, 1
  };
  localparam logic signed [31:0] RND_COEFFS [TAPS] = '{
    -3, -2048, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

  logic        clock = 1'b0;
  logic        reset;
  logic        in_i_rd_en, in_i_empty, in_q_rd_en, in_q_empty;
  logic [31:0] in_i_dout, in_q_dout;
  logic        out_i_wr_en, out_i_full, out_q_wr_en, out_q_full;
  logic [31:0] out_i_din, out_q_din;

  logic        r_in_i_rd_en, r_in_i_empty, r_in_q_rd_en, r_in_q_empty;
  logic [31:0] r_in_i_dout, r_in_q_dout;
  logic        r_out_i_wr_en, r_out_i_full, r_out_q_wr_en, r_out_q_full;
  logic [31:0] r_out_i_din, r_out_q_din;

  fir_cmplx_decim u_dut (
    .clock(clock), .reset(reset),
    .in_i_rd_en(in_i_rd_en), .in_i_empty(in_i_empty), .in_i_dout(in_i_dout),
    .in_q_rd_en(in_q_rd_en), .in_q_empty(in_q_empty), .in_q_dout(in_q_dout),
    .out_i_wr_en(out_i_wr_en), .out_i_full(out_i_full), .out_i_din(out_i_din),
    .out_q_wr_en(out_q_wr_en), .out_q_full(out_q_full), .out_q_din(out_q_din)
  );

  fir_cmplx_decim #(.COEFFS(RND_COEFFS)) u_rnd (
    .clock(clock), .reset(reset),
    .in_i_rd_en(r_in_i_rd_en), .in_i_empty(r_in_i_empty), .in_i_dout(r_in_i_dout),
    .in_q_rd_en(r_in_q_rd_en), .in_q_empty(r_in_q_empty), .in_q_dout(r_in_q_dout),
    .out_i_wr_en(r_out_i_wr_en), .out_i_full(r_out_i_full), .out_i_din(r_out_i_din),
    .out_q_wr_en(r_out_q_wr_en), .out_q_full(r_out_q_full), .out_q_din(r_out_q_din)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, pops = 0, last_pop_cyc = 0;
  bit lat_check = 0, auto_exp = 0;
  bit hold_q_empty = 0, full_i = 0, full_q = 0;

  logic [31:0] fi[$], fq[$], ri[$], rq[$];
  int exp_i[$], exp_q[$], r_exp_i[$], r_exp_q[$];
  int mh_i [TAPS];
  int mh_q [TAPS];
  int mcnt = 0;
  int e_i, e_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s at cycle %0d", name, msg, cyc);
  endtask

  function automatic int fir(input int h [TAPS]);
    int acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      acc += int'((longint'(C[k]) * longint'(h[k])) / SCALE);
    end
    return acc;
  endfunction

  function automatic void drive_inputs();
    in_i_empty   = (fi.size() == 0);
    in_i_dout    = (fi.size() == 0) ? 32'd0 : fi[0];
    in_q_empty   = (fq.size() == 0) || hold_q_empty;
    in_q_dout    = (fq.size() == 0) ? 32'd0 : fq[0];
    out_i_full   = full_i;
    out_q_full   = full_q;
    r_in_i_empty = (ri.size() == 0);
    r_in_i_dout  = (ri.size() == 0) ? 32'd0 : ri[0];
    r_in_q_empty = (rq.size() == 0);
    r_in_q_dout  = (rq.size() == 0) ? 32'd0 : rq[0];
    r_out_i_full = 1'b0;
    r_out_q_full = 1'b0;
  endfunction

  // FIFO models: consume on the edge where rd_en is seen, update flags 1ns later.
  always @(posedge clock) begin
    cyc++;
    if (in_i_rd_en && fi.size() > 0) void'(fi.pop_front());
    if (in_q_rd_en && fq.size() > 0) void'(fq.pop_front());
    if (in_i_rd_en && in_q_rd_en) begin
      pops++;
      last_pop_cyc = cyc;
    end
    if (r_in_i_rd_en && ri.size() > 0) void'(ri.pop_front());
    if (r_in_q_rd_en && rq.size() > 0) void'(rq.pop_front());
    #1;
    drive_inputs();
  end

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset) begin
      if (in_i_rd_en || in_q_rd_en)
        check("rd_pair", {30'd0, in_i_rd_en, in_q_rd_en}, 32'd3);
      if (out_i_wr_en || out_q_wr_en) begin
        check("wr_pair", {30'd0, out_i_wr_en, out_q_wr_en}, 32'd3);
        check("wr_while_full", {30'd0, out_i_full, out_q_full}, 32'd0);
        if (exp_i.size() == 0) begin
          fail_now("unexpected_write", $sformatf("got i=%0d q=%0d, none pending",
                   $signed(out_i_din), $signed(out_q_din)));
        end else begin
          e_i = exp_i.pop_front();
          e_q = exp_q.pop_front();
          check("out_i", out_i_din, e_i);
          check("out_q", out_q_din, e_q);
          if (lat_check) begin
            check("latency", 32'(cyc + 1 - last_pop_cyc), 32'(TAPS + 1));
            lat_check = 0;
          end
        end
      end
      if (r_out_i_wr_en || r_out_q_wr_en) begin
        check("rnd_wr_pair", {30'd0, r_out_i_wr_en, r_out_q_wr_en}, 32'd3);
        if (r_exp_i.size() == 0) begin
          fail_now("rnd_unexpected_write", $sformatf("got i=%0d q=%0d",
                   $signed(r_out_i_din), $signed(r_out_q_din)));
        end else begin
          e_i = r_exp_i.pop_front();
          e_q = r_exp_q.pop_front();
          check("rnd_out_i", r_out_i_din, e_i);
          check("rnd_out_q", r_out_q_din, e_q);
        end
      end
    end
  end

  task automatic send(input int i, input int q);
    fi.push_back(i);
    fq.push_back(q);
    for (int k = TAPS - 1; k > 0; k--) begin
      mh_i[k] = mh_i[k-1];
      mh_q[k] = mh_q[k-1];
    end
    mh_i[0] = i;
    mh_q[0] = q;
    mcnt++;
    if (mcnt == DECIM) begin
      mcnt = 0;
      if (auto_exp) begin
        exp_i.push_back(fir(mh_i));
        exp_q.push_back(fir(mh_q));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fi.delete(); fq.delete(); ri.delete(); rq.delete();
    exp_i.delete(); exp_q.delete(); r_exp_i.delete(); r_exp_q.delete();
    for (int k = 0; k < TAPS; k++) begin
      mh_i[k] = 0;
      mh_q[k] = 0;
    end
    mcnt = 0;
    hold_q_empty = 0;
    full_i = 0;
    full_q = 0;
    lat_check = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_i.size() != 0 || r_exp_i.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_i.size() != 0 || r_exp_i.size() != 0)
      fail_now(name, $sformatf("timeout, %0d outputs still pending", exp_i.size() + r_exp_i.size()));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((fi.size() != 0 || fq.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (fi.size() != 0 || fq.size() != 0)
      fail_now(name, $sformatf("timeout, %0d samples not popped", fi.size()));
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (pops < target)
      fail_now(name, $sformatf("timeout, pops %0d of %0d", pops, target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      mh_i[k] = 0;
      mh_q[k] = 0;
    end
    drive_inputs();

    // Reset state, with data waiting in the input FIFOs.
    fi.push_back(32'd5);
    fq.push_back(32'd5);
    repeat (2) @(negedge clock);
    check("rst_rd_i", in_i_rd_en, 0);
    check("rst_rd_q", in_q_rd_en, 0);
    check("rst_wr_i", out_i_wr_en, 0);
    check("rst_wr_q", out_q_wr_en, 0);
    check("rst_din_i", out_i_din, 0);
    check("rst_din_q", out_q_din, 0);
    check("rst_rnd_din_i", r_out_i_din, 0);

    // Impulse on I: COEFFS[9], COEFFS[19], then zeros; Q stays zero.
    do_reset();
    auto_exp = 0;
    exp_i = '{181, 1, 0, 0};
    exp_q = '{0, 0, 0, 0};
    lat_check = 1;
    send(1024, 0);
    for (int k = 1; k < 40; k++) send(0, 0);
    wait_idle("impulse", 600);

    // DC 1024 on both channels: partial sum, then full sum of COEFFS.
    do_reset();
    exp_i = '{512, 1053, 1053, 1053};
    exp_q = '{512, 1053, 1053, 1053};
    for (int k = 0; k < 40; k++) send(1024, 1024);
    wait_idle("dc", 600);

    // Flag skew: Q held empty mid-stream while I has data.
    do_reset();
    auto_exp = 1;
    for (int k = 1; k <= 3; k++) send(100 * k + 37, -(50 * k) - 11);
    wait_drain("skew_first", 100);
    @(negedge clock);
    hold_q_empty = 1;
    for (int k = 4; k <= 10; k++) send(100 * k + 37, -(50 * k) - 11);
    @(posedge clock);
    repeat (5) begin
      @(negedge clock);
      check("skew_rd_i", in_i_rd_en, 0);
      check("skew_rd_q", in_q_rd_en, 0);
    end
    check("skew_no_pop", 32'(fi.size()), 32'd7);
    hold_q_empty = 0;
    wait_idle("skew", 200);

    // Backpressure: Q output full while in S_OUT.
    do_reset();
    full_q = 1;
    for (int k = 1; k <= 10; k++) send(4000 * k - 25000, 333 * (k % 3) - 700);
    wait_drain("bp_drain", 200);
    repeat (TAPS + 4) @(negedge clock);
    for (int k = 1; k <= 10; k++) send(-(k * 1234), k * 5678);
    repeat (8) begin
      @(negedge clock);
      check("bp_wr_i", out_i_wr_en, 0);
      check("bp_wr_q", out_q_wr_en, 0);
      check("bp_rd", {31'd0, in_i_rd_en | in_q_rd_en}, 0);
      check("bp_din_i", out_i_din, exp_i[0]);
      check("bp_din_q", out_q_din, exp_q[0]);
    end
    check("bp_no_pop", 32'(fi.size()), 32'd10);
    full_q = 0;
    wait_idle("bp", 400);

    // Reset at tap 7 of S_MAC, then a fresh decimation window.
    do_reset();
    p0 = pops;
    for (int k = 1; k <= 10; k++) send(50000 + k * 1000, -(70000 + k));
    wait_pops("mac_pops", p0 + 10, 200);
    repeat (7) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("macrst_rd_i", in_i_rd_en, 0);
    check("macrst_rd_q", in_q_rd_en, 0);
    check("macrst_wr_i", out_i_wr_en, 0);
    check("macrst_wr_q", out_q_wr_en, 0);
    check("macrst_din_i", out_i_din, 0);
    check("macrst_din_q", out_q_din, 0);
    do_reset();
    for (int k = 1; k <= 9; k++) send(-(k * 977), k * k * 41);
    repeat (TAPS + DECIM + 5) @(negedge clock);
    send(-(10 * 977), 100 * 41);
    wait_idle("macrst", 200);

    // Round toward zero: sparse table on the second instance.
    do_reset();
    auto_exp = 0;
    r_exp_i = '{-2, -2};
    r_exp_q = '{0, 2};
    for (int k = 1; k <= 20; k++) begin
      ri.push_back((k == 9) ? 32'd1 : (k == 20) ? 32'd683 : 32'd0);
      rq.push_back((k == 10) ? 32'd1 : (k == 19) ? 32'hFFFF_FFFF : 32'd0);
    end
    wait_idle("rounding", 300);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
